// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Request/response and RAM-side bus of the memory access sequencer.
//   master : control unit / RAM side. Drives req, rw, size, addr and MFC.
//            Observes ram_addr, the strobes, beat, busy, done and the traps.
//   slave  : the sequencer (mem_access_ctrl).
interface mem_access_ctrl_if;
  logic        req;
  logic        rw;
  logic [1:0]  size;
  logic [31:0] addr;
  logic        MFC;
  logic [31:0] ram_addr;
  logic        mar_load;
  logic        RAM_enable;
  logic        mdr_load;
  logic        temp_load;
  logic        beat;
  logic        busy;
  logic        done;
  logic        trap_misaligned;
  logic        trap_timeout;

  modport master (
    output req, rw, size, addr, MFC,
    input  ram_addr, mar_load, RAM_enable, mdr_load, temp_load,
           beat, busy, done, trap_misaligned, trap_timeout
  );

  modport slave (
    input  req, rw, size, addr, MFC,
    output ram_addr, mar_load, RAM_enable, mdr_load, temp_load,
           beat, busy, done, trap_misaligned, trap_timeout
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences one load/store at a time between the control unit and the
//   RAM/MAR/MDR/TEMP path. It checks alignment, drives RAM_enable while it
//   waits for MFC (bounded by TIMEOUT_CYCLES) and splits doublewords into
//   two word beats.
//   Clk : rising-edge clock
//   Clr : synchronous active-high reset
//   bus : mem_access_ctrl_if.slave. Inputs are req/rw/size/addr/MFC.
//         Outputs are ram_addr, mar_load, RAM_enable, mdr_load, temp_load,
//         beat, busy, done, trap_misaligned and trap_timeout.
//
//   state  | meaning
//   IDLE   | waiting for req; latch request, check alignment
//   SETUP  | mar_load pulse with ram_addr = addr + 4*beat
//   ACCESS | RAM_enable high, waiting for MFC or timeout
//   GAP    | one dead cycle between doubleword beats
//   DONE   | done pulse plus trap flag, then back to IDLE
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              Clk,
  input  logic              Clr,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, GAP, DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        rw_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [7:0]  wait_cnt;
  logic [31:0] ram_addr_q;
  logic        mar_load_q;
  logic        ram_enable_q;
  logic        beat_q;
  logic        busy_q;
  logic        done_q;
  logic        trap_mis_q;
  logic        trap_to_q;
  logic        misaligned;

  assign misaligned = ((bus.size == 2'b01) && bus.addr[0]) ||
                      ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00)) ||
                      ((bus.size == 2'b11) && (bus.addr[2:0] != 3'b000));

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state        <= IDLE;
      rw_q         <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= 32'd0;
      wait_cnt     <= 8'd0;
      ram_addr_q   <= 32'd0;
      mar_load_q   <= 1'b0;
      ram_enable_q <= 1'b0;
      beat_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trap_mis_q   <= 1'b0;
      trap_to_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            rw_q     <= bus.rw;
            size_q   <= bus.size;
            addr_q   <= bus.addr;
            beat_q   <= 1'b0;
            wait_cnt <= 8'd0;
            busy_q   <= 1'b1;
            if (misaligned) begin
              state      <= DONE;
              done_q     <= 1'b1;
              trap_mis_q <= 1'b1;
            end else begin
              state      <= SETUP;
              mar_load_q <= 1'b1;
              ram_addr_q <= bus.addr;
            end
          end
        end
        SETUP: begin
          mar_load_q   <= 1'b0;
          ram_enable_q <= 1'b1;
          wait_cnt     <= 8'd0;
          state        <= ACCESS;
        end
        ACCESS: begin
          if (bus.MFC) begin
            ram_enable_q <= 1'b0;
            if ((size_q == 2'b11) && !beat_q) begin
              state <= GAP;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            ram_enable_q <= 1'b0;
            state        <= DONE;
            done_q       <= 1'b1;
            trap_to_q    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        GAP: begin
          // Doubleword alignment keeps the +4 from carrying past bit 2.
          beat_q     <= 1'b1;
          ram_addr_q <= addr_q + 32'd4;
          mar_load_q <= 1'b1;
          state      <= SETUP;
        end
        DONE: begin
          done_q     <= 1'b0;
          trap_mis_q <= 1'b0;
          trap_to_q  <= 1'b0;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_addr        = ram_addr_q;
  assign bus.mar_load        = mar_load_q;
  assign bus.RAM_enable      = ram_enable_q;
  assign bus.beat            = beat_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.trap_misaligned = trap_mis_q;
  assign bus.trap_timeout    = trap_to_q;

  // The MDR/TEMP strobes follow MFC combinationally. RAM_Out is only
  // guaranteed valid in the MFC cycle, so a registered strobe would be late.
  assign bus.mdr_load  = (state == ACCESS) && bus.MFC && rw_q && !beat_q;
  assign bus.temp_load = (state == ACCESS) && bus.MFC && rw_q &&  beat_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam int T = 4;
  localparam int NEVER = 1000;

  logic Clk = 1'b0;
  logic Clr = 1'b1;
  always #5 Clk = ~Clk;

  mem_access_ctrl_if bus();
  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (.Clk(Clk), .Clr(Clr), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    int          lat;
    int          en;
    int          mdr_n;
    int          temp_n;
    int          mar_n;
    int          bad;
    logic        tm;
    logic        tt;
    logic        idle_busy;
    logic [31:0] a0;
    logic [31:0] a1;
  } res_t;

  // Expected transaction summary from the access rules: cycle counts per
  // phase, word addresses per beat, strobe counts and trap outcome.
  function automatic res_t model(logic rw_i, logic [1:0] sz, logic [31:0] a,
                                 int w0, int w1);
    res_t e;
    int   w[2];
    int   beats;
    bit   mis;
    e = '0;
    w[0] = w0;
    w[1] = w1;
    mis = (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
          (sz == 2'd3 && a % 8 != 0);
    if (mis) begin
      e.lat = 1;
      e.tm  = 1'b1;
      return e;
    end
    beats = (sz == 2'd3) ? 2 : 1;
    for (int b = 0; b < beats; b++) begin
      e.lat   += 1;
      e.mar_n += 1;
      if (w[b] >= T) begin
        e.lat += T;
        e.en  += T;
        e.tt   = 1'b1;
        break;
      end
      e.lat += w[b] + 1;
      e.en  += w[b] + 1;
      if (rw_i) begin
        if (b == 0) e.mdr_n += 1;
        else        e.temp_n += 1;
      end
      if (b < beats - 1) e.lat += 1;
    end
    e.lat += 1;
    e.a0 = a;
    e.a1 = (e.mar_n == 2) ? a + 32'd4 : 32'd0;
    return e;
  endfunction

  // Issues one request and watches the DUT until done; MFC is raised on the
  // (w+1)-th RAM_enable cycle of each beat. Returns in the IDLE cycle after DONE.
  task automatic run_txn(input logic rw_i, input logic [1:0] sz,
                         input logic [31:0] a, input int w0, input int w1,
                         input bit hold, output res_t r);
    int w[2];
    int acc;
    int wb;
    r = '0;
    r.lat = -1;
    w[0] = w0;
    w[1] = w1;
    acc = 0;
    bus.req  = 1'b1;
    bus.rw   = rw_i;
    bus.size = sz;
    bus.addr = a;
    @(posedge Clk); #1;
    if (!hold) begin
      bus.req  = 1'b0;
      bus.rw   = 1'($urandom);
      bus.size = 2'($urandom);
      bus.addr = $urandom;
    end
    for (int k = 1; k <= 300; k++) begin
      if (bus.mar_load) begin
        r.mar_n++;
        if (r.mar_n == 1) r.a0 = bus.ram_addr;
        else              r.a1 = bus.ram_addr;
        acc = 0;
      end
      if (bus.RAM_enable) begin
        r.en++;
        acc++;
      end
      wb = (r.mar_n >= 2) ? w[1] : w[0];
      bus.MFC = bus.RAM_enable && (acc == wb + 1);
      #1;
      if (bus.mdr_load)  r.mdr_n++;
      if (bus.temp_load) r.temp_n++;
      if (bus.done) begin
        r.lat = k;
        r.tm  = bus.trap_misaligned;
        r.tt  = bus.trap_timeout;
        break;
      end
      if (!bus.busy) r.bad++;
      if (bus.trap_misaligned || bus.trap_timeout) r.bad++;
      @(posedge Clk); #1;
    end
    bus.MFC = 1'b0;
    @(posedge Clk); #1;
    r.idle_busy = bus.busy;
  endtask

  task automatic test_reset();
    Clr = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    n_cmp++;
    if ({bus.ram_addr, bus.mar_load, bus.RAM_enable, bus.mdr_load, bus.temp_load,
         bus.beat, bus.busy, bus.done, bus.trap_misaligned, bus.trap_timeout} !== 41'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: ram_addr=%h mar=%b en=%b busy=%b done=%b required all 0",
               bus.ram_addr, bus.mar_load, bus.RAM_enable, bus.busy, bus.done);
    end
    Clr = 1'b0;
    @(posedge Clk); #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_busy: got %b required 0", bus.busy);
    end
  endtask

  task automatic test_word_read();
    res_t r, e;
    run_txn(1'b1, 2'b10, 32'h100, 0, 0, 1'b0, r);
    e = model(1'b1, 2'b10, 32'h100, 0, 0);
    n_cmp++;
    if (r !== e) begin
      n_bad++;
      $display("FAIL word_read: got lat=%0d en=%0d mdr=%0d a0=%h tm=%b tt=%b bad=%0d required lat=%0d en=%0d mdr=%0d a0=%h",
               r.lat, r.en, r.mdr_n, r.a0, r.tm, r.tt, r.bad, e.lat, e.en, e.mdr_n, e.a0);
    end
    n_cmp++;
    if (r.lat !== 3) begin
      n_bad++;
      $display("FAIL word_read_latency: got %0d required 3", r.lat);
    end
  endtask

  task automatic test_dword_read();
    res_t r, e;
    run_txn(1'b1, 2'b11, 32'h8, 2, 2, 1'b0, r);
    e = model(1'b1, 2'b11, 32'h8, 2, 2);
    n_cmp++;
    if (r !== e) begin
      n_bad++;
      $display("FAIL dword_read: got lat=%0d en=%0d mdr=%0d temp=%0d a0=%h a1=%h bad=%0d required lat=%0d en=%0d a0=%h a1=%h",
               r.lat, r.en, r.mdr_n, r.temp_n, r.a0, r.a1, r.bad, e.lat, e.en, e.a0, e.a1);
    end
    n_cmp++;
    if (r.lat !== 10 || r.a1 !== 32'hC || r.temp_n !== 1) begin
      n_bad++;
      $display("FAIL dword_read_fixed: got lat=%0d a1=%h temp=%0d required 10 0000000c 1",
               r.lat, r.a1, r.temp_n);
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [31:0] ad[4] = '{32'h101, 32'h102, 32'h104, 32'h103};
    res_t r, e;
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, sz[i], ad[i], 1, 1, 1'b0, r);
      e = model(1'b1, sz[i], ad[i], 1, 1);
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL misaligned_%0d: got lat=%0d en=%0d tm=%b mar=%0d required lat=%0d en=%0d tm=%b mar=%0d",
                 i, r.lat, r.en, r.tm, r.mar_n, e.lat, e.en, e.tm, e.mar_n);
      end
    end
  endtask

  task automatic test_timeout();
    res_t r, e;
    run_txn(1'b0, 2'b10, 32'h200, NEVER, NEVER, 1'b0, r);
    e = model(1'b0, 2'b10, 32'h200, NEVER, NEVER);
    n_cmp++;
    if (r !== e) begin
      n_bad++;
      $display("FAIL timeout: got lat=%0d en=%0d tt=%b tm=%b mdr=%0d required lat=%0d en=%0d tt=%b",
               r.lat, r.en, r.tt, r.tm, r.mdr_n, e.lat, e.en, e.tt);
    end
    n_cmp++;
    if (r.en !== T || r.mdr_n + r.temp_n !== 0) begin
      n_bad++;
      $display("FAIL timeout_enable_cycles: got en=%0d loads=%0d required %0d 0",
               r.en, r.mdr_n + r.temp_n, T);
    end
  endtask

  task automatic test_clr_abort();
    res_t r, e;
    int   dones;
    bus.req  = 1'b1;
    bus.rw   = 1'b1;
    bus.size = 2'b11;
    bus.addr = 32'h8;
    bus.MFC  = 1'b0;
    @(posedge Clk); #1;
    bus.req = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    n_cmp++;
    if (bus.RAM_enable !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_in_access: RAM_enable got %b required 1", bus.RAM_enable);
    end
    Clr = 1'b1;
    @(posedge Clk); #1;
    n_cmp++;
    if ({bus.ram_addr, bus.mar_load, bus.RAM_enable, bus.mdr_load, bus.temp_load,
         bus.beat, bus.busy, bus.done, bus.trap_misaligned, bus.trap_timeout} !== 41'd0) begin
      n_bad++;
      $display("FAIL abort_outputs: ram_addr=%h en=%b busy=%b done=%b required all 0",
               bus.ram_addr, bus.RAM_enable, bus.busy, bus.done);
    end
    Clr = 1'b0;
    dones = 0;
    repeat (5) begin
      @(posedge Clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL abort_quiet: got %0d active cycles required 0", dones);
    end
    run_txn(1'b1, 2'b10, 32'h40, 1, 0, 1'b0, r);
    e = model(1'b1, 2'b10, 32'h40, 1, 0);
    n_cmp++;
    if (r !== e) begin
      n_bad++;
      $display("FAIL abort_recover: got lat=%0d en=%0d mdr=%0d a0=%h required lat=%0d en=%0d mdr=%0d a0=%h",
               r.lat, r.en, r.mdr_n, r.a0, e.lat, e.en, e.mdr_n, e.a0);
    end
  endtask

  task automatic test_back_to_back();
    res_t r, e;
    run_txn(1'b0, 2'b00, 32'h10, 0, 0, 1'b1, r);
    e = model(1'b0, 2'b00, 32'h10, 0, 0);
    n_cmp++;
    if (r !== e) begin
      n_bad++;
      $display("FAIL b2b_first: got lat=%0d mar=%0d idle_busy=%b bad=%0d required lat=%0d mar=%0d idle_busy=0",
               r.lat, r.mar_n, r.idle_busy, r.bad, e.lat, e.mar_n);
    end
    run_txn(1'b0, 2'b00, 32'h11, 0, 0, 1'b0, r);
    e = model(1'b0, 2'b00, 32'h11, 0, 0);
    n_cmp++;
    if (r !== e) begin
      n_bad++;
      $display("FAIL b2b_second: got lat=%0d mar=%0d a0=%h required lat=%0d mar=%0d a0=%h",
               r.lat, r.mar_n, r.a0, e.lat, e.mar_n, e.a0);
    end
  endtask

  task automatic test_random();
    res_t        r, e;
    logic        rw_i;
    logic [1:0]  sz;
    logic [31:0] a;
    int          w0, w1;
    for (int i = 0; i < 40; i++) begin
      rw_i = 1'($urandom);
      sz   = 2'($urandom);
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
      w0 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 5));
      w1 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 5));
      run_txn(rw_i, sz, a, w0, w1, 1'b0, r);
      e = model(rw_i, sz, a, w0, w1);
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL random_%0d rw=%b sz=%0d a=%h w=%0d/%0d: got lat=%0d en=%0d mdr=%0d temp=%0d tm=%b tt=%b a0=%h a1=%h bad=%0d required lat=%0d en=%0d mdr=%0d temp=%0d tm=%b tt=%b a0=%h a1=%h",
                 i, rw_i, sz, a, w0, w1, r.lat, r.en, r.mdr_n, r.temp_n, r.tm, r.tt, r.a0, r.a1, r.bad,
                 e.lat, e.en, e.mdr_n, e.temp_n, e.tm, e.tt, e.a0, e.a1);
      end
    end
  endtask

  initial begin
    bus.req  = 1'b0;
    bus.rw   = 1'b0;
    bus.size = 2'b00;
    bus.addr = 32'd0;
    bus.MFC  = 1'b0;
    test_reset();
    test_word_read();
    test_dword_read();
    test_misaligned();
    test_timeout();
    test_clr_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
